// File: rtl/bus_arb_8.sv
// Round-robin arbiter/sequencer for the shared 8-source, 8-bit select mux.
// Bounded tenure per owner and a one-cycle turnaround gap between owners.
module bus_arb_8 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    input  logic       lock,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       bus_valid,
    output logic       preempt
);

    localparam int         NUM_SRC = 8;
    localparam logic [7:0] HMAX    = 8'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t     state, nstate;
    logic [7:0] hold, nhold;
    logic [2:0] last, nlast, nsel, win, idx;
    logic       found, others, npre;

    // First asserted request at or after last+1, wrapping; last itself is tried last.
    always_comb begin
        win   = last;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = last + 3'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign others = |(req & ~(8'b1 << sel));

    always_comb begin
        nstate = state;
        nhold  = hold;
        nsel   = sel;
        nlast  = last;
        npre   = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (|req) begin
                    nstate = BUSY;
                    nsel   = win;
                    nlast  = win;
                    nhold  = '0;
                end else begin
                    nstate = IDLE;
                end
            end
            BUSY: begin
                if (!req[sel]) begin
                    nstate = GAP;
                end else if (hold == HMAX && others && !lock) begin
                    nstate = GAP;
                    npre   = 1'b1;
                end else if (hold != HMAX) begin
                    nhold = hold + 8'd1;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decision so gnt and sel move together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            hold      <= '0;
            sel       <= '0;
            last      <= 3'd7;
            gnt       <= '0;
            bus_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= nstate;
            hold      <= nhold;
            sel       <= nsel;
            last      <= nlast;
            preempt   <= npre;
            bus_valid <= (nstate == BUSY);
            gnt       <= (nstate == BUSY) ? (8'b1 << nsel) : 8'b0;
        end
    end

endmodule

// File: tb/tb_bus_arb_8.sv
// Randomised and directed bench for bus_arb_8 against a cycle-level ownership model.
module tb_bus_arb_8;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] req = '0;
    logic       lock = 1'b0;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       bus_valid;
    logic       preempt;

    int total = 0;
    int bad   = 0;

    bus_arb_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .lock(lock),
        .gnt(gnt), .sel(sel), .bus_valid(bus_valid), .preempt(preempt)
    );

    always #5 clk = ~clk;

    // Model: who owns the bus, how long they have held it, who won last.
    int m_owner = -1;
    int m_last  = 7;
    int m_sel   = 0;
    int m_ten   = 0;
    bit m_pre   = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner = -1; m_last = 7; m_sel = 0; m_ten = 0; m_pre = 1'b0;
        end else if (m_owner >= 0) begin
            m_pre = 1'b0;
            if (!req[m_owner]) begin
                m_owner = -1;
            end else if (m_ten + 1 >= MAX_HOLD && (req & ~(8'(1) << m_owner)) != 0 && !lock) begin
                m_owner = -1;
                m_pre   = 1'b1;
            end else begin
                m_ten++;
            end
        end else begin
            m_pre = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (m_last + k) % 8;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c; m_last = c; m_sel = c; m_ten = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare();
        chk("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("sel", 32'(sel), 32'(m_sel));
        chk("bus_valid", 32'(bus_valid), 32'(m_owner >= 0));
        chk("preempt", 32'(preempt), 32'(m_pre));
    endtask

    task automatic step(input logic [7:0] r, input logic l);
        req  = r;
        lock = l;
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        #3;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_valid", 32'(bus_valid), 32'd0);
        chk("rst_pre", 32'(preempt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // first grant goes to source 0, then full rotation under constant contention
        step(8'hFF, 1'b0);
        chk("first_gnt", 32'(gnt), 32'h01);
        repeat (45) step(8'hFF, 1'b0);
        repeat (3) step(8'h00, 1'b0);

        // normal release, new request lands during the gap
        repeat (2) step(8'h04, 1'b0);
        step(8'h00, 1'b0);
        chk("norm_rel_pre", 32'(preempt), 32'd0);
        step(8'h20, 1'b0);
        chk("gap_regrant", 32'(gnt), 32'h20);
        repeat (3) step(8'h00, 1'b0);

        // lock exempts owner 3 from preemption
        step(8'h08, 1'b0);
        repeat (10) step(8'h88, 1'b1);
        chk("lock_hold", 32'(gnt), 32'h08);
        repeat (3) step(8'h88, 1'b0);
        repeat (3) step(8'h00, 1'b0);

        // sole requester keeps the bus
        repeat (20) step(8'h40, 1'b0);
        chk("sole_hold", 32'(gnt), 32'h40);
        repeat (2) step(8'h00, 1'b0);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom) & 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            step(r, ($urandom_range(0, 3) == 0));
        end

        // async reset while source 4 owns the bus
        repeat (3) step(8'h00, 1'b0);
        repeat (2) step(8'h10, 1'b0);
        chk("pre_rst_gnt", 32'(gnt), 32'h10);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_valid", 32'(bus_valid), 32'd0);
        #1 reset_n = 1'b1;
        step(8'h11, 1'b0);
        chk("post_rst_gnt", 32'(gnt), 32'h01);
        repeat (10) step(8'h11, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
